// File: rtl/gps_cfg_pkg.sv
// -----------------------------------------------------------------------------
// gps_cfg_pkg
// Shared types and constants for the PMOD GPS power-up configuration sequencer:
// state encoding, PMTK sentence lengths, ASCII line terminators and the two
// literal sentences streamed to the receiver.
// -----------------------------------------------------------------------------
package gps_cfg_pkg;

    // Encoding is exported on state_o for LEDs, so values are fixed.
    typedef enum logic [2:0] {
        ST_BOOT_WAIT  = 3'd0,
        ST_SEND_BAUD  = 3'd1,
        ST_DRAIN_BAUD = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_SEND_RATE  = 3'd4,
        ST_DRAIN_RATE = 3'd5,
        ST_RUN        = 3'd6,
        ST_ERR        = 3'd7
    } state_e;

    localparam int MSG_BAUD_LEN = 19;
    localparam int MSG_RATE_LEN = 17;
    localparam int MAX_MSG_LEN  = 19;
    localparam int IDX_W        = $clog2(MAX_MSG_LEN);

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    // Checksums are the XOR of all characters between '$' and '*'.
    localparam logic [8*MSG_BAUD_LEN-1:0] MSG_BAUD = {"$PMTK251,38400*27", CR, LF};
    localparam logic [8*MSG_RATE_LEN-1:0] MSG_RATE = {"$PMTK220,100*2F", CR, LF};

endpackage

// File: rtl/gps_cfg_seq_if.sv
// -----------------------------------------------------------------------------
// gps_cfg_seq_if
// Byte-wide valid/ready link from the configuration sequencer to the UART TX.
//   tx_valid : byte on tx_data is valid (sequencer -> UART)
//   tx_data  : ASCII byte to transmit   (sequencer -> UART)
//   tx_ready : UART accepts byte this cycle (UART -> sequencer)
//   tx_idle  : UART shifter empty, line idle (UART -> sequencer)
// -----------------------------------------------------------------------------
interface gps_cfg_seq_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_idle;

    modport master (output tx_valid, output tx_data, input tx_ready, input tx_idle);
    modport slave  (input tx_valid, input tx_data, output tx_ready, output tx_idle);
endinterface

// File: rtl/pmtk_rom.sv
// -----------------------------------------------------------------------------
// pmtk_rom
// Combinational lookup of the two PMTK configuration sentences.
//   msg_sel_i : 0 = baud sentence, 1 = update-rate sentence
//   idx_i     : byte index within the sentence
//   byte_o    : character at idx_i, 8'h00 when idx_i is past the end
//   last_o    : idx_i addresses the final LF of the selected sentence
// -----------------------------------------------------------------------------
module pmtk_rom
    import gps_cfg_pkg::*;
(
    input  logic             msg_sel_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [7:0]       byte_o,
    output logic             last_o
);

    // Byte 0 sits in the most significant byte of each packed sentence.
    always_comb begin
        byte_o = 8'h00;
        last_o = 1'b0;
        if (msg_sel_i == 1'b0) begin
            if (idx_i < IDX_W'(MSG_BAUD_LEN)) begin
                byte_o = 8'(MSG_BAUD >> (8 * (MSG_BAUD_LEN - 1 - int'(idx_i))));
                last_o = (idx_i == IDX_W'(MSG_BAUD_LEN - 1));
            end else begin
                byte_o = 8'h00;
                last_o = 1'b0;
            end
        end else begin
            if (idx_i < IDX_W'(MSG_RATE_LEN)) begin
                byte_o = 8'(MSG_RATE >> (8 * (MSG_RATE_LEN - 1 - int'(idx_i))));
                last_o = (idx_i == IDX_W'(MSG_RATE_LEN - 1));
            end else begin
                byte_o = 8'h00;
                last_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gps_cfg_seq.sv
// -----------------------------------------------------------------------------
// gps_cfg_seq
// Power-up configuration sequencer for the PMOD GPS. After a boot delay it
// sends the 38400 Bd sentence at 9600 Bd, waits for the line to drain, flips
// the local baud select, settles, sends the 10 Hz sentence, then enables the
// receive path. A stalled link or a TX that never goes idle aborts to ERR.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   start_i         : restart pulse, honoured only in RUN or ERR
//   tx_if (master)  : byte link into the UART transmitter
//   baud_sel_o      : 0 = 9600 Bd, 1 = 38400 Bd
//   rx_enable_o     : gates received bytes into the decoder
//   done_o, error_o : completion / abort levels
//   state_o         : current state encoding
// -----------------------------------------------------------------------------
module gps_cfg_seq
    import gps_cfg_pkg::*;
#(
    parameter int BOOT_CYCLES_P    = 12000000,
    parameter int SETTLE_CYCLES_P  = 120000,
    parameter int TIMEOUT_CYCLES_P = 1200000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    gps_cfg_seq_if.master        tx_if,
    output logic                 baud_sel_o,
    output logic                 rx_enable_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [2:0]           state_o
);

    localparam int WAIT_MAX = (BOOT_CYCLES_P > SETTLE_CYCLES_P) ? BOOT_CYCLES_P : SETTLE_CYCLES_P;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int STALL_W  = $clog2(TIMEOUT_CYCLES_P + 1);
    localparam logic [WAIT_W-1:0]  BOOT_LAST   = WAIT_W'(BOOT_CYCLES_P - 1);
    localparam logic [WAIT_W-1:0]  SETTLE_LAST = WAIT_W'(SETTLE_CYCLES_P - 1);
    localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'(TIMEOUT_CYCLES_P - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               baud_sel_q, baud_sel_d;
    logic               rx_enable_q, rx_enable_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               handshake_s;
    logic               stall_tick_s;
    logic               rom_sel_s;
    logic [7:0]         rom_byte_s;
    logic               rom_last_s;

    // The ROM is addressed with the next-cycle message and index so tx_data
    // and the last-byte flag can be registered alongside tx_valid.
    pmtk_rom u_rom (
        .msg_sel_i (rom_sel_s),
        .idx_i     (idx_d),
        .byte_o    (rom_byte_s),
        .last_o    (rom_last_s)
    );

    // Next-state, counters and control outputs.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        idx_d        = idx_q;
        tx_valid_d   = tx_valid_q;
        baud_sel_d   = baud_sel_q;
        rx_enable_d  = rx_enable_q;
        done_d       = done_q;
        error_d      = error_q;
        stall_tick_s = 1'b0;
        handshake_s  = tx_valid_q && tx_if.tx_ready;

        case (state_q)
            ST_BOOT_WAIT: begin
                if (wait_cnt_q == BOOT_LAST) begin
                    state_d    = ST_SEND_BAUD;
                    wait_cnt_d = '0;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_SEND_BAUD, ST_SEND_RATE: begin
                if (handshake_s) begin
                    if (last_q) begin
                        state_d    = (state_q == ST_SEND_BAUD) ? ST_DRAIN_BAUD : ST_DRAIN_RATE;
                        idx_d      = '0;
                        tx_valid_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    stall_tick_s = tx_valid_q;
                end
            end
            ST_DRAIN_BAUD: begin
                if (tx_if.tx_idle) begin
                    state_d    = ST_SETTLE;
                    baud_sel_d = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    stall_tick_s = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (wait_cnt_q == SETTLE_LAST) begin
                    state_d    = ST_SEND_RATE;
                    wait_cnt_d = '0;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_DRAIN_RATE: begin
                if (tx_if.tx_idle) begin
                    state_d     = ST_RUN;
                    done_d      = 1'b1;
                    rx_enable_d = 1'b1;
                end else begin
                    stall_tick_s = 1'b1;
                end
            end
            ST_RUN: begin
                if (start_i) begin
                    state_d     = ST_BOOT_WAIT;
                    wait_cnt_d  = '0;
                    baud_sel_d  = 1'b0;
                    done_d      = 1'b0;
                    rx_enable_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                if (start_i) begin
                    state_d    = ST_BOOT_WAIT;
                    wait_cnt_d = '0;
                    baud_sel_d = 1'b0;
                    error_d    = 1'b0;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d    = ST_ERR;
                tx_valid_d = 1'b0;
                error_d    = 1'b1;
            end
        endcase

        // A non-stalling cycle is always a handshake or a state change, so
        // clearing on anything but a stall matches the clear conditions.
        if (stall_tick_s) begin
            if (stall_cnt_q == STALL_LAST) begin
                state_d     = ST_ERR;
                tx_valid_d  = 1'b0;
                error_d     = 1'b1;
                idx_d       = '0;
                stall_cnt_d = '0;
            end else begin
                stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end
        end else begin
            stall_cnt_d = '0;
        end
    end

    // ROM-derived byte and last flag for the cycle being entered.
    always_comb begin
        rom_sel_s = (state_d == ST_SEND_RATE);
        tx_data_d = 8'h00;
        last_d    = rom_last_s;
        if (tx_valid_d) begin
            tx_data_d = rom_byte_s;
        end else begin
            tx_data_d = 8'h00;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_BOOT_WAIT;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            baud_sel_q  <= 1'b0;
            rx_enable_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            baud_sel_q  <= baud_sel_d;
            rx_enable_q <= rx_enable_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign tx_if.tx_valid = tx_valid_q;
    assign tx_if.tx_data  = tx_data_q;
    assign baud_sel_o     = baud_sel_q;
    assign rx_enable_o    = rx_enable_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_gps_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_gps_cfg_seq
// Self-checking bench for gps_cfg_seq with short boot/settle/timeout values.
// Scenario table drives ready/idle behaviour; a byte scoreboard holds the
// expected sentence stream and is popped on every handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gps_cfg_seq;

    localparam int BOOT    = 10;
    localparam int SETTLE  = 5;
    localparam int TIMEOUT = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       baud_sel, rx_enable, done, error;
    logic [2:0] state;

    gps_cfg_seq_if bus ();

    gps_cfg_seq #(
        .BOOT_CYCLES_P    (BOOT),
        .SETTLE_CYCLES_P  (SETTLE),
        .TIMEOUT_CYCLES_P (TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .tx_if       (bus.master),
        .baud_sel_o  (baud_sel),
        .rx_enable_o (rx_enable),
        .done_o      (done),
        .error_o     (error),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ready_mode;   // 0 always ready, 1 random stalls, 2 ready drops after stall_at bytes
        int         stall_at;
        int         idle_hold;    // cycles tx_idle stays low after the first sentence
        int         start_at;     // byte count at which start is pulsed, -1 none
        logic [2:0] exp_state;
        logic       exp_done;
        logic       exp_err;
        logic       exp_baud;
        int         exp_bytes;
        int         exp_drain0;
        int         exp_max_stall; // -1 = not checked
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_stream [$];
    logic [7:0] sb_q [$];
    int         checks_total = 0;
    int         checks_passed = 0;
    int         hs_count, boot_cycles, send0_cycles, send1_cycles, drain0_cycles, settle_cycles;
    int         stall_run, max_stall, zero_run, idle_low_left;

    task automatic check(input string name, input int act, input int exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic push_sentence(input string s);
        for (int i = 0; i < s.len(); i++) exp_stream.push_back(s[i]);
        exp_stream.push_back(8'h0D);
        exp_stream.push_back(8'h0A);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.tx_ready = 1'b0;
        bus.tx_idle = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", int'(bus.tx_valid), 0);
        check("rst_data", int'(bus.tx_data), 0);
        check("rst_state", int'(state), 0);
        check("rst_flags", int'({baud_sel, rx_enable, done, error}), 0);
        rst = 1'b0;
    endtask

    // Runs one configuration pass starting just after a negedge where the DUT
    // is in BOOT_WAIT with a zero count; ends on RUN/ERR or cycle budget.
    task automatic run_seq(input vec_t v);
        bit         finished = 1'b0;
        bit         start_done = 1'b0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       ready;
        logic [7:0] exp_b;
        hs_count = 0; boot_cycles = 0; send0_cycles = 0; send1_cycles = 0;
        drain0_cycles = 0; settle_cycles = 0; stall_run = 0; max_stall = 0;
        zero_run = 0; idle_low_left = 0;
        sb_q.delete();
        foreach (exp_stream[i]) sb_q.push_back(exp_stream[i]);
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (state == 3'd6 || state == 3'd7) begin
                finished = 1'b1;
            end else begin
                if (state == 3'd0) boot_cycles++;
                if (state == 3'd1) send0_cycles++;
                if (state == 3'd2) begin
                    drain0_cycles++;
                    check("baud_in_drain", int'(baud_sel), 0);
                end
                if (state == 3'd3) settle_cycles++;
                if (state == 3'd4) send1_cycles++;
                if (prev_stall) begin
                    check("stall_data_hold", int'(bus.tx_data), int'(prev_data));
                    check("stall_valid_hold", int'(bus.tx_valid), 1);
                end
                start = 1'b0;
                if (v.start_at >= 0 && hs_count == v.start_at && !start_done) begin
                    start = 1'b1;
                    start_done = 1'b1;
                end
                case (v.ready_mode)
                    0: ready = 1'b1;
                    1: ready = (zero_run >= 10 || $urandom_range(0, 2) != 0);
                    default: ready = (hs_count < v.stall_at);
                endcase
                zero_run = ready ? 0 : zero_run + 1;
                bus.tx_ready = ready;
                bus.tx_idle = (idle_low_left == 0);
                if (idle_low_left > 0) idle_low_left--;
                if (bus.tx_valid && ready) begin
                    if (sb_q.size() > 0) begin
                        exp_b = sb_q.pop_front();
                        check("stream_byte", int'(bus.tx_data), int'(exp_b));
                    end else begin
                        check("stream_len", hs_count + 1, exp_stream.size());
                    end
                    check("baud_at_byte", int'(baud_sel), (hs_count >= 19) ? 1 : 0);
                    hs_count++;
                    if (hs_count == 19) idle_low_left = v.idle_hold;
                end
                prev_stall = bus.tx_valid && !ready;
                prev_data = bus.tx_data;
                stall_run = prev_stall ? stall_run + 1 : 0;
                if (stall_run > max_stall) max_stall = stall_run;
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("run_finished", int'(finished), 1);
        check("end_state", int'(state), int'(v.exp_state));
        check("end_done", int'(done), int'(v.exp_done));
        check("end_rx_enable", int'(rx_enable), int'(v.exp_done));
        check("end_error", int'(error), int'(v.exp_err));
        check("end_baud", int'(baud_sel), int'(v.exp_baud));
        check("end_valid", int'(bus.tx_valid), 0);
        check("byte_count", hs_count, v.exp_bytes);
        check("boot_cycles", boot_cycles, BOOT);
        check("drain0_cycles", drain0_cycles, v.exp_drain0);
        if (hs_count > 19) check("settle_cycles", settle_cycles, SETTLE);
        if (v.exp_max_stall >= 0) check("max_stall", max_stall, v.exp_max_stall);
        if (v.ready_mode == 0 && v.exp_bytes == 36) begin
            check("send0_cycles", send0_cycles, 19);
            check("send1_cycles", send1_cycles, 17);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_state", int'(state), 0);
        check("restart_flags", int'({baud_sel, rx_enable, done, error}), 0);
        check("restart_valid", int'(bus.tx_valid), 0);
    endtask

    initial begin
        int guard;
        bus.tx_ready = 1'b0;
        bus.tx_idle = 1'b1;
        push_sentence("$PMTK251,38400*27");
        push_sentence("$PMTK220,100*2F");

        //          mode stall idle start state done err baud bytes drain0 maxstall
        vecs[0] = '{0, 0,  0,  -1, 3'd6, 1'b1, 1'b0, 1'b1, 36, 1,  0};
        vecs[1] = '{1, 0,  0,  -1, 3'd6, 1'b1, 1'b0, 1'b1, 36, 1,  -1};
        vecs[2] = '{0, 0,  20, -1, 3'd6, 1'b1, 1'b0, 1'b1, 36, 21, 0};
        vecs[3] = '{0, 0,  60, -1, 3'd7, 1'b0, 1'b1, 1'b0, 19, 50, 0};
        vecs[4] = '{2, 24, 0,  -1, 3'd7, 1'b0, 1'b1, 1'b1, 24, 1,  50};
        vecs[5] = '{0, 0,  0,  3,  3'd6, 1'b1, 1'b0, 1'b1, 36, 1,  0};

        for (int n = 0; n < 6; n++) begin
            do_reset();
            run_seq(vecs[n]);
            if (state == 3'd7) pulse_start();
        end

        // Restart from RUN repeats the whole sequence identically.
        pulse_start();
        run_seq(vecs[0]);

        // Asynchronous reset between edges in the middle of the rate sentence.
        do_reset();
        bus.tx_ready = 1'b1;
        bus.tx_idle = 1'b1;
        guard = 0;
        while (state != 3'd4 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("reach_send_rate", int'(state), 4);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", int'(bus.tx_valid), 0);
        check("async_data", int'(bus.tx_data), 0);
        check("async_state", int'(state), 0);
        check("async_flags", int'({baud_sel, rx_enable, done, error}), 0);
        @(negedge clk);
        rst = 1'b0;
        run_seq(vecs[0]);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/gps_cfg_seq.md
Name: gps_cfg_seq

Overview:
Power-up configuration sequencer for the PMOD GPS receiver.
- After boot delay, streams two fixed PMTK sentences to the GPS over a byte-wide valid/ready link into the UART transmitter.
  - First sentence switches the GPS to 38400 Bd.
  - Second sentence switches the GPS to 10 Hz output.
- Switches the local UART baud select between the two sentences.
- Enables the receive path (uart_rx_alt → gpsdecode) only once configuration completes.
- Sits between reset synchronizer and the UART TX / baud generator in top.

Parameters:
BOOT_CYCLES_P, 12000000, clk cycles to wait after reset/start before first byte (GPS power-up, 1 s at 12 MHz)
SETTLE_CYCLES_P, 120000, clk cycles to hold after baud switch before second sentence (10 ms)
TIMEOUT_CYCLES_P, 1200000, max consecutive cycles tx_valid_o may stall, or wait for tx_idle_i, before error

Ports:
clk_i  in  1  system clock (12 MHz)
rst_i  in  1  reset; asynchronous, active-high
start_i  in  1  single-cycle pulse; restarts full sequence (honoured only in RUN or ERR)
tx_ready_i  in  1  UART TX accepts byte this cycle
tx_idle_i  in  1  UART TX shifter empty, line idle
tx_valid_o  out  1  byte on tx_data_o valid
tx_data_o  out  8  ASCII byte to transmit
baud_sel_o  out  1  0 = 9600 Bd, 1 = 38400 Bd, to UART baud generators
rx_enable_o  out  1  gates rx_valid into gpsdecode
done_o  out  1  configuration complete (level)
error_o  out  1  sequence aborted on timeout (level)
state_o  out  3  current state encoding, for LEDs/debug

Behaviour:
Reset (async, any state) → BOOT_WAIT.
- Reset values: tx_valid_o=0, tx_data_o=8'h00, baud_sel_o=0, rx_enable_o=0, done_o=0, error_o=0, counters=0, byte index=0.

States and transitions:
- BOOT_WAIT: count to BOOT_CYCLES_P-1, then → SEND_BAUD.
- SEND_BAUD: stream msg 0 = "$PMTK251,38400*27" CR LF (19 bytes).
  - tx_valid_o asserts the first cycle in state.
  - tx_data_o = ROM[msg][idx], stable while tx_valid_o && !tx_ready_i.
  - On handshake (tx_valid_o && tx_ready_i), idx increments next cycle.
  - Handshake on the last byte → DRAIN_BAUD, idx=0, tx_valid_o=0 next cycle.
- DRAIN_BAUD: wait for tx_idle_i=1 (sampled no earlier than the cycle after entry), then → SETTLE with baud_sel_o=1 from that edge.
- SETTLE: count SETTLE_CYCLES_P cycles, then → SEND_RATE.
- SEND_RATE: stream msg 1 = "$PMTK220,100*2F" CR LF (17 bytes), same rules as SEND_BAUD, then → DRAIN_RATE.
- DRAIN_RATE: wait tx_idle_i=1, then → RUN.
- RUN: done_o=1, rx_enable_o=1, tx_valid_o=0. start_i → BOOT_WAIT with baud_sel_o=0, done_o=0, rx_enable_o=0.
- ERR: error_o=1, tx_valid_o=0 (dropped immediately, mid-sentence allowed), baud_sel_o holds its value. start_i → BOOT_WAIT, clearing error_o and baud_sel_o.

Timeout:
- A stall counter increments each cycle with tx_valid_o && !tx_ready_i, and in DRAIN_* while !tx_idle_i.
- It clears on handshake or state change.
- Reaching TIMEOUT_CYCLES_P → ERR.

Boundaries:
- start_i in any state other than RUN/ERR is ignored.
- start_i coincident with reset: reset wins.
- tx_ready_i while tx_valid_o=0 is ignored.
- tx_ready_i held high gives one byte per cycle, so a sentence takes exactly N cycles.
- All counters are sized $clog2(max param + 1). No wrap-around is possible: each count stops at its terminal value.

state_o encoding: 0 BOOT_WAIT, 1 SEND_BAUD, 2 DRAIN_BAUD, 3 SETTLE, 4 SEND_RATE, 5 DRAIN_RATE, 6 RUN, 7 ERR.

Decomposition:
- Package gps_cfg_pkg:
  - state enum (3-bit, encoding above)
  - MSG_BAUD_LEN=19, MSG_RATE_LEN=17, MAX_MSG_LEN=19
  - ASCII CR=8'h0D, LF=8'h0A
- Sub-module pmtk_rom: purely combinational; inputs msg_sel (1 bit) and idx (5 bits); outputs byte (8 bits) and last (1 bit).
  - Out-of-range idx returns 8'h00.
  - Sentences are literal, checksums precomputed.

Test Plan (BOOT=10, SETTLE=5, TIMEOUT=50):
1. Reset release, tx_ready_i=1, tx_idle_i=1 → tx_valid_o rises cycle 11. Then 19 bytes in 19 consecutive cycles: first 8'h24 '$', bytes 17/18 = 8'h0D/8'h0A. baud_sel_o=1 before byte 1 of msg 1. Msg 1 bytes match "$PMTK220,100*2F\r\n". done_o=1, rx_enable_o=1, state_o=6.
2. tx_ready_i toggled randomly (≤10-cycle stalls) → tx_data_o stable through each stall, no byte skipped or duplicated, full 36-byte stream captured in order.
3. tx_idle_i held 0 for 20 cycles after msg 0 → baud_sel_o stays 0 until the cycle after tx_idle_i rises. tx_idle_i held 0 for 60 cycles → error_o=1, state_o=7, tx_valid_o=0. Then start_i → state 0, error_o=0, baud_sel_o=0.
4. tx_ready_i=0 for 50 cycles mid msg 1 (byte 5) → ERR, tx_valid_o drops next cycle, baud_sel_o remains 1.
5. start_i pulsed during SEND_BAUD → ignored, sequence completes normally. start_i in RUN → done_o=0, rx_enable_o=0, baud_sel_o=0, and the full sequence repeats identically.
6. Async rst_i asserted mid SEND_RATE between clock edges → all outputs reach reset values immediately, without waiting for a clock edge. After release, sequence restarts from BOOT_WAIT with idx=0.
